// File: rtl/riscv_pkg.sv
// Shared opcodes, datapath select encodings and FSM state type for the
// multicycle RISC-V control unit.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REG   = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR,
        EXECI, ALUWB, BRANCH, JAL, JALR, JALRLINK, HALT
    } state_t;

endpackage

// File: rtl/mc_fsm_if.sv
// Control bundle between the multicycle FSM (slave) and the datapath/bench (master).
interface mc_fsm_if;
    import riscv_pkg::*;

    // MemReady is a one-cycle completion strobe: the access presented this cycle
    // (fetch, load or store) is accepted on the rising edge where MemReady=1.
    logic [6:0] op;
    logic       MemReady;
    logic       PCUpdate;
    logic       Branch;
    logic       IRWrite;
    logic       RegWrite;
    logic       MemWrite;
    logic       AdrSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic [1:0] ALUOp;
    logic [1:0] ImmSrc;
    logic       Illegal;
    state_t     state;

    modport master (
        output op, MemReady,
        input  PCUpdate, Branch, IRWrite, RegWrite, MemWrite, AdrSrc,
        input  ALUSrcA, ALUSrcB, ResultSrc, ALUOp, ImmSrc, Illegal, state
    );

    modport slave (
        input  op, MemReady,
        output PCUpdate, Branch, IRWrite, RegWrite, MemWrite, AdrSrc,
        output ALUSrcA, ALUSrcB, ResultSrc, ALUOp, ImmSrc, Illegal, state
    );

endinterface

// File: rtl/mc_fsm_immsrcdec.sv
// Immediate-format selector, decoded straight from the opcode.
module immsrcdec
    import riscv_pkg::*;
(
    input  logic [6:0] op,
    output logic [1:0] ImmSrc
);

    always_comb begin
        ImmSrc = IMM_I;
        case (op)
            OP_LOAD, OP_ITYPE, OP_JALR: ImmSrc = IMM_I;
            OP_STORE:                   ImmSrc = IMM_S;
            OP_BRANCH:                  ImmSrc = IMM_B;
            OP_JAL:                     ImmSrc = IMM_J;
            default:                    ImmSrc = IMM_I;
        endcase
    end

endmodule

// File: rtl/mc_fsm.sv
// Multicycle RISC-V main control FSM with a shared instruction/data memory.
module mc_fsm
    import riscv_pkg::*;
#(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic      clk,
    input  logic      reset,
    mc_fsm_if.slave   bus
);

    state_t     state;
    state_t     next_state;
    logic       pc_update, branch, ir_write, reg_write, mem_write, adr_src, illegal;
    logic [1:0] alu_src_a, alu_src_b, result_src, alu_op;

    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        pc_update  = 1'b0;
        branch     = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        illegal    = 1'b0;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_REG;
        result_src = RES_ALUOUT;
        alu_op     = ALUOP_ADD;
        case (state)
            FETCH: begin
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                ir_write   = bus.MemReady;
                pc_update  = bus.MemReady;
                if (bus.MemReady) next_state = DECODE;
            end
            DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (bus.op)
                    OP_LOAD, OP_STORE: next_state = MEMADR;
                    OP_RTYPE:          next_state = EXECR;
                    OP_ITYPE:          next_state = EXECI;
                    OP_BRANCH:         next_state = BRANCH;
                    OP_JAL:            next_state = JAL;
                    OP_JALR:           next_state = JALR;
                    default: begin
                        // In NOP mode the flag is a one-cycle report; in halt mode HALT owns it.
                        next_state = HALT_ON_ILLEGAL ? HALT : FETCH;
                        illegal    = !HALT_ON_ILLEGAL;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a  = SRCA_REG;
                alu_src_b  = SRCB_IMM;
                next_state = (bus.op == OP_LOAD) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                adr_src = 1'b1;
                if (bus.MemReady) next_state = MEMWB;
            end
            MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
                next_state = FETCH;
            end
            MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (bus.MemReady) next_state = FETCH;
            end
            EXECR: begin
                alu_src_a  = SRCA_REG;
                alu_op     = ALUOP_FUNCT;
                next_state = ALUWB;
            end
            EXECI: begin
                alu_src_a  = SRCA_REG;
                alu_src_b  = SRCB_IMM;
                alu_op     = ALUOP_FUNCT;
                next_state = ALUWB;
            end
            ALUWB: begin
                reg_write  = 1'b1;
                next_state = FETCH;
            end
            BRANCH: begin
                alu_src_a  = SRCA_REG;
                alu_op     = ALUOP_SUB;
                branch     = 1'b1;
                next_state = FETCH;
            end
            JAL: begin
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                pc_update  = 1'b1;
                next_state = ALUWB;
            end
            JALR: begin
                alu_src_a  = SRCA_REG;
                alu_src_b  = SRCB_IMM;
                result_src = RES_ALURESULT;
                pc_update  = 1'b1;
                next_state = JALRLINK;
            end
            JALRLINK: begin
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                reg_write  = 1'b1;
                next_state = FETCH;
            end
            HALT: begin
                illegal = 1'b1;
            end
            default: next_state = FETCH;
        endcase
    end

    // Architectural side effects are suppressed for the whole reset cycle.
    assign bus.PCUpdate  = pc_update & ~reset;
    assign bus.Branch    = branch    & ~reset;
    assign bus.IRWrite   = ir_write  & ~reset;
    assign bus.RegWrite  = reg_write & ~reset;
    assign bus.MemWrite  = mem_write & ~reset;
    assign bus.Illegal   = illegal   & ~reset;
    assign bus.AdrSrc    = adr_src;
    assign bus.ALUSrcA   = alu_src_a;
    assign bus.ALUSrcB   = alu_src_b;
    assign bus.ResultSrc = result_src;
    assign bus.ALUOp     = alu_op;
    assign bus.state     = state;

    immsrcdec u_immsrcdec (
        .op     (bus.op),
        .ImmSrc (bus.ImmSrc)
    );

endmodule

// File: tb/tb_mc_fsm.sv
// Bench for mc_fsm: per-instruction phase model, table vectors, random programs
// and hand-written reset/illegal-opcode sequences.
module tb_mc_fsm;
    import riscv_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    mc_fsm_if bus();
    mc_fsm_if bus_nop();

    mc_fsm #(.HALT_ON_ILLEGAL(1'b1)) dut (.clk(clk), .reset(reset), .bus(bus));
    mc_fsm #(.HALT_ON_ILLEGAL(1'b0)) dut_nop (.clk(clk), .reset(reset), .bus(bus_nop));

    always #5 clk = ~clk;

    logic [14:0] ctl_a, ctl_b;
    assign ctl_a = {bus.PCUpdate, bus.Branch, bus.IRWrite, bus.RegWrite, bus.MemWrite, bus.AdrSrc,
                    bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.ALUOp, bus.Illegal};
    assign ctl_b = {bus_nop.PCUpdate, bus_nop.Branch, bus_nop.IRWrite, bus_nop.RegWrite,
                    bus_nop.MemWrite, bus_nop.AdrSrc, bus_nop.ALUSrcA, bus_nop.ALUSrcB,
                    bus_nop.ResultSrc, bus_nop.ALUOp, bus_nop.Illegal};

    typedef struct {
        logic [6:0] op;
        int         wf;
        int         wm;
        int         cycles;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic legal_op(input logic [6:0] op);
        return op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                          7'b1100011, 7'b1101111, 7'b1100111};
    endfunction

    function automatic logic [1:0] exp_imm(input logic [6:0] op);
        case (op)
            7'b0000011, 7'b0010011, 7'b1100111: return 2'b00;
            7'b0100011: return 2'b01;
            7'b1100011: return 2'b10;
            7'b1101111: return 2'b11;
            default:    return 2'b00;
        endcase
    endfunction

    // Control word a state must present, straight from the per-state output lists.
    function automatic logic [14:0] exp_ctl(input state_t s, input logic rdy, input logic [6:0] op,
                                            input logic halt_mode, input logic rst);
        logic pcu, br, irw, rw, mw, adr, ill;
        logic [1:0] sa, sb, rs, aop;
        {pcu, br, irw, rw, mw, adr, ill} = 7'b0;
        {sa, sb, rs, aop} = 8'b0;
        case (s)
            FETCH:    begin sb = 2'b10; rs = 2'b10; irw = rdy; pcu = rdy; end
            DECODE:   begin sa = 2'b01; sb = 2'b01; ill = !halt_mode && !legal_op(op); end
            MEMADR:   begin sa = 2'b10; sb = 2'b01; end
            MEMREAD:  begin adr = 1'b1; end
            MEMWB:    begin rs = 2'b01; rw = 1'b1; end
            MEMWRITE: begin adr = 1'b1; mw = 1'b1; end
            EXECR:    begin sa = 2'b10; aop = 2'b10; end
            EXECI:    begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
            ALUWB:    begin rw = 1'b1; end
            BRANCH:   begin sa = 2'b10; aop = 2'b01; br = 1'b1; end
            JAL:      begin sa = 2'b01; sb = 2'b10; pcu = 1'b1; end
            JALR:     begin sa = 2'b10; sb = 2'b01; rs = 2'b10; pcu = 1'b1; end
            JALRLINK: begin sa = 2'b01; sb = 2'b10; rs = 2'b10; rw = 1'b1; end
            HALT:     begin ill = 1'b1; end
            default:  ;
        endcase
        if (rst) {pcu, br, irw, rw, mw, ill} = 6'b0;
        return {pcu, br, irw, rw, mw, adr, sa, sb, rs, aop, ill};
    endfunction

    task automatic check_main(input string tag, input state_t s);
        chk({tag, ".state"}, 32'(bus.state), 32'(s));
        chk({tag, ".ctl"}, 32'(ctl_a), 32'(exp_ctl(s, bus.MemReady, bus.op, 1'b1, reset)));
        chk({tag, ".imm"}, 32'(bus.ImmSrc), 32'(exp_imm(bus.op)));
    endtask

    task automatic check_nop(input string tag, input state_t s);
        chk({tag, ".state"}, 32'(bus_nop.state), 32'(s));
        chk({tag, ".ctl"}, 32'(ctl_b), 32'(exp_ctl(s, bus_nop.MemReady, bus_nop.op, 1'b0, reset)));
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_cycles(input logic [6:0] op, input int wf, input int wm);
        case (op)
            7'b0000011: return 5 + wf + wm;
            7'b0100011: return 4 + wf + wm;
            7'b1100011: return 3 + wf;
            default:    return 4 + wf;
        endcase
    endfunction

    // Expands one instruction into its phase list, drives it, and measures how many
    // cycles the DUT takes to come back to FETCH.
    task automatic run_instr(input string tag, input logic [6:0] op, input int wf, input int wm,
                             output int measured);
        state_t sq[$];
        logic   rq[$];
        state_t s;
        logic   r;
        logic   seen_dec;
        int     n;
        for (int i = 0; i < wf; i++) begin sq.push_back(FETCH); rq.push_back(1'b0); end
        sq.push_back(FETCH);  rq.push_back(1'b1);
        sq.push_back(DECODE); rq.push_back(1'($urandom));
        case (op)
            7'b0000011, 7'b0100011: begin
                sq.push_back(MEMADR); rq.push_back(1'($urandom));
                s = (op == 7'b0000011) ? MEMREAD : MEMWRITE;
                for (int i = 0; i < wm; i++) begin sq.push_back(s); rq.push_back(1'b0); end
                sq.push_back(s); rq.push_back(1'b1);
                if (op == 7'b0000011) begin sq.push_back(MEMWB); rq.push_back(1'($urandom)); end
            end
            7'b0110011: begin sq.push_back(EXECR); sq.push_back(ALUWB); end
            7'b0010011: begin sq.push_back(EXECI); sq.push_back(ALUWB); end
            7'b1100011: sq.push_back(BRANCH);
            7'b1101111: begin sq.push_back(JAL); sq.push_back(ALUWB); end
            default:    begin sq.push_back(JALR); sq.push_back(JALRLINK); end
        endcase
        while (rq.size() < sq.size()) rq.push_back(1'($urandom));
        measured = -1;
        seen_dec = 1'b0;
        n = 0;
        while (sq.size() > 0) begin
            s = sq.pop_front();
            r = rq.pop_front();
            bus.MemReady = r;
            bus.op = (s == DECODE || s == MEMADR) ? op : 7'($urandom);
            @(negedge clk);
            check_main(tag, s);
            if (bus.state == DECODE) seen_dec = 1'b1;
            else if (bus.state == FETCH && seen_dec && measured < 0) measured = n;
            n++;
            next_cycle();
        end
        bus.MemReady = 1'b0;
        bus.op = 7'($urandom);
        @(negedge clk);
        check_main({tag, ".end"}, FETCH);
        if (bus.state == FETCH && seen_dec && measured < 0) measured = n;
        next_cycle();
    endtask

    vec_t       tbl[8];
    logic [6:0] ops[7];
    int         meas;

    initial begin
        tbl[0] = '{7'b0000011, 0, 0, 5};
        tbl[1] = '{7'b0000011, 1, 2, 8};
        tbl[2] = '{7'b0100011, 0, 3, 7};
        tbl[3] = '{7'b0110011, 0, 0, 4};
        tbl[4] = '{7'b0010011, 2, 0, 6};
        tbl[5] = '{7'b1100011, 0, 0, 3};
        tbl[6] = '{7'b1101111, 0, 0, 4};
        tbl[7] = '{7'b1100111, 1, 0, 5};
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                7'b1100011, 7'b1101111, 7'b1100111};

        // Reset: writes suppressed even with MemReady high in FETCH.
        reset = 1'b1;
        bus.op = 7'($urandom);
        bus.MemReady = 1'b1;
        bus_nop.op = 7'b0;
        bus_nop.MemReady = 1'b1;
        next_cycle();
        @(negedge clk);
        check_main("reset", FETCH);
        check_nop("reset_nop", FETCH);
        next_cycle();
        reset = 1'b0;
        bus.MemReady = 1'b0;
        bus_nop.MemReady = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_instr($sformatf("vec%0d", i), tbl[i].op, tbl[i].wf, tbl[i].wm, meas);
            chk($sformatf("vec%0d.cycles", i), 32'(meas), 32'(tbl[i].cycles));
        end

        for (int i = 0; i < 40; i++) begin
            logic [6:0] op;
            int wf, wm;
            op = ops[$urandom_range(0, 6)];
            wf = $urandom_range(0, 2);
            wm = $urandom_range(0, 3);
            run_instr($sformatf("rnd%0d", i), op, wf, wm, meas);
            chk($sformatf("rnd%0d.cycles", i), 32'(meas), 32'(exp_cycles(op, wf, wm)));
        end

        // Illegal opcode halts until reset.
        bus.MemReady = 1'b1;
        @(negedge clk); check_main("ill.fetch", FETCH); next_cycle();
        bus.op = 7'b1111111;
        @(negedge clk); check_main("ill.decode", DECODE); next_cycle();
        for (int i = 0; i < 12; i++) begin
            bus.op = 7'($urandom);
            bus.MemReady = 1'($urandom);
            @(negedge clk); check_main($sformatf("ill.halt%0d", i), HALT); next_cycle();
        end
        reset = 1'b1;
        @(negedge clk); check_main("ill.reset", HALT); next_cycle();
        reset = 1'b0;
        bus.MemReady = 1'b0;
        @(negedge clk); check_main("ill.after", FETCH); next_cycle();

        // Reset while waiting in MEMREAD.
        bus.MemReady = 1'b1;
        @(negedge clk); check_main("rmr.fetch", FETCH); next_cycle();
        bus.op = 7'b0000011;
        @(negedge clk); check_main("rmr.decode", DECODE); next_cycle();
        @(negedge clk); check_main("rmr.memadr", MEMADR); next_cycle();
        bus.MemReady = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); check_main($sformatf("rmr.wait%0d", i), MEMREAD); next_cycle();
        end
        reset = 1'b1;
        @(negedge clk); check_main("rmr.reset", MEMREAD); next_cycle();
        reset = 1'b0;
        @(negedge clk); check_main("rmr.after", FETCH); next_cycle();

        // NOP-mode instance: illegal op pulses Illegal in DECODE and returns to FETCH.
        bus_nop.MemReady = 1'b1;
        @(negedge clk); check_nop("nop.fetch", FETCH); next_cycle();
        bus_nop.op = 7'b1111111;
        bus_nop.MemReady = 1'b0;
        @(negedge clk); check_nop("nop.decode", DECODE); next_cycle();
        @(negedge clk); check_nop("nop.back", FETCH); next_cycle();
        bus_nop.MemReady = 1'b1;
        @(negedge clk); check_nop("nop.fetch2", FETCH); next_cycle();
        bus_nop.op = 7'b1100011;
        @(negedge clk); check_nop("nop.decode2", DECODE); next_cycle();
        @(negedge clk); check_nop("nop.branch", BRANCH); next_cycle();
        bus_nop.MemReady = 1'b0;
        @(negedge clk); check_nop("nop.end", FETCH); next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
